hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core (F/D/E/M/W). It consumes the per-instruction hazard descriptor produced in D: Tuse, Tnew and the source/destination register indices. It keeps a three-entry scoreboard for the E, M and W stages, advanced every clock. From that scoreboard it drives the D-stage stall, the ID/EX bubble insertion and the forwarding selects for the D, E and M operand muxes.

## Interface
- `RA_W`, default 5, width of a register index.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears the scoreboard.
- `d_rs`  in  RA_W  rs index read by the D instruction; 0 means no read.
- `d_rt`  in  RA_W  rt index read by the D instruction; 0 means no read.
- `d_rd`  in  RA_W  destination index of the D instruction; 0 means no write.
- `d_tuse`  in  2  cycles from D until the source value is needed (0 = D, 1 = E, 2 = no hazard-relevant use).
- `d_tnew`  in  2  cycles after entering E until the result exists (0 = at E, 1 = end of E, 2 = end of M).
- `stall`  out  1  freeze PC and IF/ID; ID/EX loads a bubble.
- `fwd_d_rs`, `fwd_d_rt`  out  2  D operand source: 0 = RF, 1 = E result, 2 = M result, 3 = W result.
- `fwd_e_rs`, `fwd_e_rt`  out  2  E operand source: 0 = ID/EX value, 2 = M result, 3 = W result.
- `fwd_m_rt`  out  1  M store-data source: 0 = EX/MEM value, 1 = W result.

## Operation
- Scoreboard registers:
  - E: `rs`, `rt`, `dst`, `tnew`.
  - M: `rt`, `dst`, `tnew`.
  - W: `dst`.
- Stall, evaluated combinationally from the current scoreboard and D inputs:
  - For each source `s` in {`d_rs`, `d_rt`} with `s` ≠ 0, a hazard exists if either condition holds:
    - `s == E.dst` and `E.tnew > d_tuse`, or
    - `s == M.dst` and `M.tnew > d_tuse`.
  - `stall` is the OR of the two sources.
  - `d_tuse == 2` never stalls, because no Tnew exceeds 2.
- Forwarding, evaluated combinationally. A source only matches a stage whose `dst` ≠ 0. The nearest stage wins.
  - D selects: priority E (only if `E.tnew == 0`), then M (only if `M.tnew == 0`), then W, otherwise 0.
  - E selects on `E.rs`/`E.rt`: priority M (only if `M.tnew == 0`), then W, otherwise 0.
  - M select: `fwd_m_rt = (M.rt != 0 && M.rt == W.dst)`.
- Register `$0`: a match on index 0 never stalls and never forwards.

## Timing
- Every rising edge with `reset` = 0:
  - W.dst ← M.dst.
  - M ← E, with tnew ← max(E.tnew − 1, 0).
  - E ← D fields when `stall` = 0.
  - E ← bubble (all fields 0) when `stall` = 1.
- Every rising edge with `reset` = 1: all scoreboard fields become 0. From the first cycle after reset, `stall` = 0 and all `fwd_*` = 0. A reset in the middle of a stall aborts the stall on the next cycle.
- `stall` and all `fwd_*` are combinational, valid in the same cycle as the D inputs. There is no added latency.
- During a stall, the upstream stage holds the D inputs stable, so the same instruction is re-evaluated each cycle until `stall` drops.
- Simultaneous match in E and M: E has priority for forwarding, and either stage alone can cause a stall.
- A stage's tnew of 0 stays 0; there is no underflow.

## Structure
- Shared package `hazard_pkg` holds:
  - the `fwd_sel_t` encodings (`FWD_RF`/`FWD_E`/`FWD_M`/`FWD_W`);
  - the Tuse/Tnew constants (`TUSE_D`, `TUSE_E`, `TUSE_NONE`, `TNEW_E`, `TNEW_M`);
  - the scoreboard entry struct.
- Sub-module `hazard_sb_stage` is a single scoreboard stage register with saturating tnew decrement and bubble load. It is instantiated three times.

## Test plan
- Load then ALU use: lw `$1` (tnew 2), then addu rs=`$1` (tuse 1). Required:
  - `stall` = 1 for exactly one cycle;
  - when addu reaches E, `fwd_e_rs` = 3.
- Load then branch: lw `$2`, then beq rs=`$2` (tuse 0). Required:
  - `stall` = 1 for two cycles;
  - no forward is needed, because W writes the register file.
- ALU then branch: addu `$3`, then beq rt=`$3`. Required:
  - `stall` = 1 for one cycle;
  - the next cycle, `fwd_d_rt` = 2.
- jal then jr: jal (dst 31, tnew 0), then jr rs=31. Required: `stall` = 0 and `fwd_d_rs` = 1.
- Zero register: lw `$0`, then addu rs=`$0`. Required: `stall` = 0 and all `fwd_*` = 0.
- Reset mid-stall: lw `$4`, beq `$4`, assert `reset` during the first stall cycle. Required:
  - the next cycle, `stall` = 0;
  - the scoreboard reads all zero.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   fwd_sel_t   - operand-mux select encodings (RF / E / M / W result)
//   TUSE_*      - cycles from D until a source operand is consumed
//   TNEW_*      - cycles after entering E until a result is produced
//   sb_entry_t  - one scoreboard stage (source indices, destination, tnew)
//   tnew_dec    - saturating tnew decrement applied as an entry ages
package hazard_pkg;

  localparam int SB_RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_t;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_NONE = 2'd2;
  localparam logic [1:0] TNEW_E    = 2'd1;
  localparam logic [1:0] TNEW_M    = 2'd2;

  typedef struct packed {
    logic [SB_RA_W-1:0] rs;
    logic [SB_RA_W-1:0] rt;
    logic [SB_RA_W-1:0] dst;
    logic [1:0]         tnew;
  } sb_entry_t;

  // A result that already exists stays available; tnew never wraps.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if
// Bundle between the decode stage and the hazard controller.
//   d_rs/d_rt/d_rd    - register indices of the D instruction (0 = unused)
//   d_tuse/d_tnew     - hazard descriptor of the D instruction
//   stall             - freeze PC and IF/ID, bubble into ID/EX
//   fwd_d_*/fwd_e_*   - operand forwarding selects for D and E muxes
//   fwd_m_rt          - store-data forward from W into M
// master = decode side, slave = hazard controller.
interface hazard_if #(parameter int RA_W = 5);
  import hazard_pkg::*;

  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [RA_W-1:0] d_rd;
  logic [1:0]      d_tuse;
  logic [1:0]      d_tnew;
  logic            stall;
  fwd_sel_t        fwd_d_rs;
  fwd_sel_t        fwd_d_rt;
  fwd_sel_t        fwd_e_rs;
  fwd_sel_t        fwd_e_rt;
  logic            fwd_m_rt;

  modport master (
    output d_rs, d_rt, d_rd, d_tuse, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_rs, d_rt, d_rd, d_tuse, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

endinterface

// File: rtl/hazard_sb_stage.sv
// hazard_sb_stage
// One scoreboard stage register.
//   clk, reset  - rising-edge clock, synchronous active-high clear
//   bubble      - load an all-zero entry instead of entry_i
//   dec_tnew    - age tnew by one cycle (saturating at 0) while loading
//   entry_i     - entry arriving from the previous stage
//   entry_o     - registered entry held by this stage
module hazard_sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble,
  input  logic      dec_tnew,
  input  sb_entry_t entry_i,
  output sb_entry_t entry_o
);

  sb_entry_t entry_d;
  sb_entry_t entry_q;

  // Next entry: pass through, optionally aged; a bubble overrides everything.
  always_comb begin
    entry_d = entry_i;
    if (dec_tnew) begin
      entry_d.tnew = tnew_dec(entry_i.tnew);
    end
    if (bubble) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall / forwarding controller for the five-stage F/D/E/M/W pipeline.
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   hz (slave)  - D-stage hazard descriptor in, stall and forwarding out
// Keeps an E/M/W scoreboard of in-flight destinations and their remaining
// time-to-result; all outputs are combinational from that scoreboard and D.
module hazard_ctrl
  import hazard_pkg::*;
(
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);

  sb_entry_t d_entry;
  sb_entry_t e_q;
  sb_entry_t m_q;
  sb_entry_t w_q;
  logic      stall;
  logic      unused_fields;

  // A source stalls when a producer in E or M cannot deliver before use.
  function automatic logic src_hazard(input logic [SB_RA_W-1:0] s,
                                      input logic [1:0] tuse,
                                      input sb_entry_t e,
                                      input sb_entry_t m);
    logic hit;
    hit = 1'b0;
    if (s != '0) begin
      hit = ((s == e.dst) && (e.tnew > tuse)) ||
            ((s == m.dst) && (m.tnew > tuse));
    end
    return hit;
  endfunction

  // Nearest stage whose result already exists wins; W always has its value.
  function automatic fwd_sel_t fwd_d_sel(input logic [SB_RA_W-1:0] s,
                                         input sb_entry_t e,
                                         input sb_entry_t m,
                                         input sb_entry_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (s != '0) begin
      if ((s == e.dst) && (e.tnew == 2'd0)) begin
        sel = FWD_E;
      end else if ((s == m.dst) && (m.tnew == 2'd0)) begin
        sel = FWD_M;
      end else if (s == w.dst) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  function automatic fwd_sel_t fwd_e_sel(input logic [SB_RA_W-1:0] s,
                                         input sb_entry_t m,
                                         input sb_entry_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (s != '0) begin
      if ((s == m.dst) && (m.tnew == 2'd0)) begin
        sel = FWD_M;
      end else if (s == w.dst) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  // Pack the D instruction into a scoreboard entry for the E stage.
  always_comb begin
    d_entry      = '0;
    d_entry.rs   = hz.d_rs;
    d_entry.rt   = hz.d_rt;
    d_entry.dst  = hz.d_rd;
    d_entry.tnew = hz.d_tnew;
  end

  // E takes the D instruction or a bubble; M ages E; W only needs dst.
  hazard_sb_stage u_e (
    .clk(clk), .reset(reset), .bubble(stall), .dec_tnew(1'b0),
    .entry_i(d_entry), .entry_o(e_q)
  );

  hazard_sb_stage u_m (
    .clk(clk), .reset(reset), .bubble(1'b0), .dec_tnew(1'b1),
    .entry_i(e_q), .entry_o(m_q)
  );

  hazard_sb_stage u_w (
    .clk(clk), .reset(reset), .bubble(1'b0), .dec_tnew(1'b0),
    .entry_i(m_q), .entry_o(w_q)
  );

  // Stall and all forwarding selects, same cycle as the D inputs.
  always_comb begin
    stall       = src_hazard(hz.d_rs, hz.d_tuse, e_q, m_q) |
                  src_hazard(hz.d_rt, hz.d_tuse, e_q, m_q);
    hz.stall    = stall;
    hz.fwd_d_rs = fwd_d_sel(hz.d_rs, e_q, m_q, w_q);
    hz.fwd_d_rt = fwd_d_sel(hz.d_rt, e_q, m_q, w_q);
    hz.fwd_e_rs = fwd_e_sel(e_q.rs, m_q, w_q);
    hz.fwd_e_rt = fwd_e_sel(e_q.rt, m_q, w_q);
    hz.fwd_m_rt = (m_q.rt != '0) && (m_q.rt == w_q.dst);
  end

  // Fields carried by the shared stage type but not consulted downstream.
  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, with expected outputs from an age-based model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_if #(.RA_W(5)) hz ();

  hazard_ctrl dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  // In-flight instruction as issued; pipe[k] is k+1 stages past D (0 = E).
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    int         tnew;
  } instr_t;

  typedef struct {
    logic       stall;
    logic [1:0] fdrs;
    logic [1:0] fdrt;
    logic [1:0] fers;
    logic [1:0] fert;
    logic       fmrt;
  } expect_t;

  instr_t  pipe[3];
  instr_t  cur;
  bit      cur_rst;
  bit      model_stall;
  expect_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  function automatic instr_t empty_instr();
    instr_t i;
    i.rs = '0; i.rt = '0; i.dst = '0; i.tnew = 0;
    return i;
  endfunction

  // Cycles still needed before the instruction at pipe[k] has its result.
  function automatic int remaining(input int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic bit model_hazard(input logic [4:0] s, input int tuse);
    if (s == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].dst == s && remaining(k) > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] s, input int first_k);
    if (s == 5'd0) return 2'd0;
    for (int k = first_k; k < 3; k++) begin
      if (pipe[k].dst == s && remaining(k) == 0) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Present one D instruction and queue the model's expected response.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [1:0] tuse,
                               input logic [1:0] tnew, input bit rst);
    expect_t e;
    hz.d_rs   = rs;
    hz.d_rt   = rt;
    hz.d_rd   = rd;
    hz.d_tuse = tuse;
    hz.d_tnew = tnew;
    reset     = rst;
    cur.rs = rs; cur.rt = rt; cur.dst = rd; cur.tnew = int'(tnew);
    cur_rst = rst;
    model_stall = model_hazard(rs, int'(tuse)) || model_hazard(rt, int'(tuse));
    e.stall = model_stall;
    e.fdrs  = model_fwd(rs, 0);
    e.fdrt  = model_fwd(rt, 0);
    e.fers  = model_fwd(pipe[0].rs, 1);
    e.fert  = model_fwd(pipe[0].rt, 1);
    e.fmrt  = (pipe[1].rt != 5'd0) && (pipe[1].rt == pipe[2].dst);
    exp_q.push_back(e);
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    if (cur_rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = empty_instr();
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = model_stall ? empty_instr() : cur;
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, TUSE_NONE, 2'd0, 1'b0);
      advanceCycle();
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare on each falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("mon_stall",    hz.stall,    e.stall);
        checkOutput("mon_fwd_d_rs", hz.fwd_d_rs, e.fdrs);
        checkOutput("mon_fwd_d_rt", hz.fwd_d_rt, e.fdrt);
        checkOutput("mon_fwd_e_rs", hz.fwd_e_rs, e.fers);
        checkOutput("mon_fwd_e_rt", hz.fwd_e_rt, e.fert);
        checkOutput("mon_fwd_m_rt", hz.fwd_m_rt, e.fmrt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] rs, rt, rd;
    logic [1:0] tuse, tnew;
    bit         rst, hold;

    for (int k = 0; k < 3; k++) pipe[k] = empty_instr();
    reset = 1'b1;
    hz.d_rs = '0; hz.d_rt = '0; hz.d_rd = '0; hz.d_tuse = TUSE_NONE; hz.d_tnew = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(5'd0, 5'd0, 5'd0, TUSE_NONE, 2'd0, 1'b0);
    #1;
    checkOutput("reset_stall", hz.stall, 0);
    checkOutput("reset_fwd_d_rs", hz.fwd_d_rs, 0);
    advanceCycle();

    // Load then ALU use: one stall, then W forwards into E.
    applyStimulus(5'd0, 5'd0, 5'd1, TUSE_NONE, TNEW_M, 1'b0);
    advanceCycle();
    applyStimulus(5'd1, 5'd0, 5'd5, TUSE_E, TNEW_E, 1'b0);
    #1; checkOutput("ld_use_stall1", hz.stall, 1);
    advanceCycle();
    applyStimulus(5'd1, 5'd0, 5'd5, TUSE_E, TNEW_E, 1'b0);
    #1; checkOutput("ld_use_stall2", hz.stall, 0);
    advanceCycle();
    applyStimulus(5'd0, 5'd0, 5'd0, TUSE_NONE, 2'd0, 1'b0);
    #1; checkOutput("ld_use_fwd_e_rs", hz.fwd_e_rs, 3);
    advanceCycle();
    nops(3);

    // Load then branch: two stall cycles.
    applyStimulus(5'd0, 5'd0, 5'd2, TUSE_NONE, TNEW_M, 1'b0);
    advanceCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd2, 5'd0, 5'd0, TUSE_D, 2'd0, 1'b0);
      #1; checkOutput($sformatf("ld_br_stall%0d", i), hz.stall, (i < 2) ? 1 : 0);
      advanceCycle();
    end
    nops(3);

    // ALU then branch: one stall, then M forwards into D.
    applyStimulus(5'd0, 5'd0, 5'd3, TUSE_E, TNEW_E, 1'b0);
    advanceCycle();
    applyStimulus(5'd0, 5'd3, 5'd0, TUSE_D, 2'd0, 1'b0);
    #1; checkOutput("alu_br_stall1", hz.stall, 1);
    advanceCycle();
    applyStimulus(5'd0, 5'd3, 5'd0, TUSE_D, 2'd0, 1'b0);
    #1; checkOutput("alu_br_stall2", hz.stall, 0);
    checkOutput("alu_br_fwd_d_rt", hz.fwd_d_rt, 2);
    advanceCycle();
    nops(3);

    // jal then jr: link value available in E immediately.
    applyStimulus(5'd0, 5'd0, 5'd31, TUSE_NONE, 2'd0, 1'b0);
    advanceCycle();
    applyStimulus(5'd31, 5'd0, 5'd0, TUSE_D, 2'd0, 1'b0);
    #1; checkOutput("jal_jr_stall", hz.stall, 0);
    checkOutput("jal_jr_fwd_d_rs", hz.fwd_d_rs, 1);
    advanceCycle();
    nops(3);

    // Register $0 never stalls or forwards.
    applyStimulus(5'd0, 5'd0, 5'd0, TUSE_NONE, TNEW_M, 1'b0);
    advanceCycle();
    applyStimulus(5'd0, 5'd0, 5'd6, TUSE_E, TNEW_E, 1'b0);
    #1; checkOutput("zero_stall", hz.stall, 0);
    checkOutput("zero_fwd_d_rs", hz.fwd_d_rs, 0);
    advanceCycle();
    nops(3);

    // Reset during the first stall cycle aborts the stall.
    applyStimulus(5'd0, 5'd0, 5'd4, TUSE_NONE, TNEW_M, 1'b0);
    advanceCycle();
    applyStimulus(5'd4, 5'd0, 5'd0, TUSE_D, 2'd0, 1'b1);
    #1; checkOutput("rst_mid_stall_before", hz.stall, 1);
    advanceCycle();
    applyStimulus(5'd4, 5'd0, 5'd0, TUSE_D, 2'd0, 1'b0);
    #1; checkOutput("rst_mid_stall_after", hz.stall, 0);
    checkOutput("rst_mid_fwd_d_rs", hz.fwd_d_rs, 0);
    checkOutput("rst_sb_e", dut.e_q, 0);
    checkOutput("rst_sb_m", dut.m_q, 0);
    checkOutput("rst_sb_w", dut.w_q, 0);
    advanceCycle();
    nops(3);

    // Random stream: small register range for frequent dependencies;
    // a stalled instruction is held until it issues.
    hold = 1'b0;
    rs = '0; rt = '0; rd = '0; tuse = TUSE_NONE; tnew = '0;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        rs   = 5'($urandom_range(0, 7));
        rt   = 5'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 7));
        tuse = 2'($urandom_range(0, 2));
        tnew = 2'($urandom_range(0, 2));
      end
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(rs, rt, rd, tuse, tnew, rst);
      hold = model_stall && !rst;
      advanceCycle();
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
